// File: rtl/cs_dac_seg_ctrl.sv
// Digital front-end for the segmented current-steering DAC: a two-stage code pipeline with
// static/DWA thermometer decode, complementary switch drives and a SAR trim sequencer.
module cs_dac_seg_ctrl #(
  parameter int unsigned LSB_BITS   = 6,
  parameter int unsigned MSB_BITS   = 4,
  parameter int unsigned CAL_BITS   = 5,
  parameter int unsigned CAL_MAX    = 22,
  parameter int unsigned CAL_RESET  = 11,
  parameter int unsigned CAL_SETTLE = 16
) (
  input  logic                               clk,
  input  logic                               rstb,
  input  logic                               pdb,
  input  logic [LSB_BITS+MSB_BITS-1:0]       code,
  input  logic                               code_valid,
  input  logic                               mode,
  input  logic                               cal_start,
  input  logic                               cal_cmp,
  output logic [LSB_BITS-1:0]                datain,
  output logic [LSB_BITS-1:0]                datainb,
  output logic [(2**MSB_BITS)-2:0]           datatherm,
  output logic [(2**MSB_BITS)-2:0]           datathermb,
  output logic [CAL_BITS-1:0]                dataical,
  output logic                               cal_busy,
  output logic                               cal_done
);

  localparam int unsigned CODE_BITS = LSB_BITS + MSB_BITS;
  localparam int unsigned THERM     = (2 ** MSB_BITS) - 1;
  localparam int unsigned CNT_BITS  = (CAL_SETTLE > 1) ? $clog2(CAL_SETTLE) : 1;
  localparam int unsigned BIT_W     = (CAL_BITS > 1) ? $clog2(CAL_BITS) : 1;

  // ---------------------------------------------------------------------------------------------
  // Code pipeline
  // ---------------------------------------------------------------------------------------------
  logic [CODE_BITS-1:0] s1_code_q;
  logic                 s1_mode_q;
  logic                 s1_new_q;
  logic [LSB_BITS-1:0]  din_q;
  logic [THERM-1:0]     therm_q;
  logic [MSB_BITS-1:0]  ptr_q;

  logic [MSB_BITS-1:0]  k;
  logic [THERM-1:0]     lin;
  logic [2*THERM-1:0]   dbl;
  logic [THERM-1:0]     therm_d;
  logic [MSB_BITS:0]    ptr_sum;
  logic [MSB_BITS-1:0]  ptr_d;

  assign k = s1_code_q[CODE_BITS-1 -: MSB_BITS];

  always_comb begin
    lin = '0;
    for (int unsigned i = 0; i < THERM; i++) begin
      lin[i] = (i < 32'(k));
    end
    // Rotating a doubled copy gives the wrap-around modulo THERM for free.
    dbl     = {lin, lin} << ptr_q;
    therm_d = s1_mode_q ? dbl[2*THERM-1:THERM] : lin;
    ptr_sum = {1'b0, ptr_q} + {1'b0, k};
    if (ptr_sum >= (MSB_BITS+1)'(THERM)) begin
      ptr_d = MSB_BITS'(ptr_sum - (MSB_BITS+1)'(THERM));
    end else begin
      ptr_d = ptr_sum[MSB_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb || !pdb) begin
      s1_code_q <= '0;
      s1_mode_q <= 1'b0;
      s1_new_q  <= 1'b0;
      din_q     <= '0;
      therm_q   <= '0;
      ptr_q     <= '0;
    end else begin
      s1_new_q <= code_valid;
      if (code_valid) begin
        s1_code_q <= code;
        s1_mode_q <= mode;
      end
      // Only freshly accepted codes are decoded, so DWA does not re-rotate on idle cycles.
      if (s1_new_q) begin
        din_q   <= s1_code_q[LSB_BITS-1:0];
        therm_q <= therm_d;
        if (s1_mode_q) begin
          ptr_q <= ptr_d;
        end
      end
    end
  end

  assign datain     = din_q;
  assign datainb    = ~din_q;
  assign datatherm  = therm_q;
  assign datathermb = ~therm_q;

  // ---------------------------------------------------------------------------------------------
  // SAR calibration sequencer
  // ---------------------------------------------------------------------------------------------
  typedef enum logic [1:0] {StIdle, StSettle, StDecide, StDone} cal_state_e;

  cal_state_e          state_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic [BIT_W-1:0]    bit_q;
  logic [CAL_BITS-1:0] ical_q;
  logic [CAL_BITS-1:0] last_q;
  logic                busy_q;
  logic                done_q;

  logic [CAL_BITS-1:0] decided;
  logic [CAL_BITS-1:0] clamped;

  always_comb begin
    decided = ical_q;
    if (cal_cmp) begin
      decided[bit_q] = 1'b0;
    end
    if (bit_q != '0) begin
      decided[bit_q - 1'b1] = 1'b1;
    end
    clamped = (decided > CAL_BITS'(CAL_MAX)) ? CAL_BITS'(CAL_MAX) : decided;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      ical_q  <= CAL_BITS'(CAL_RESET);
      last_q  <= CAL_BITS'(CAL_RESET);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (!pdb) begin
      // Abort: fall back to the last trim that completed.
      state_q <= StIdle;
      cnt_q   <= '0;
      ical_q  <= last_q;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cal_start) begin
            state_q <= StSettle;
            cnt_q   <= '0;
            bit_q   <= BIT_W'(CAL_BITS - 1);
            ical_q  <= {1'b1, {(CAL_BITS-1){1'b0}}};
            busy_q  <= 1'b1;
          end
        end
        StSettle: begin
          if (cnt_q == CNT_BITS'(CAL_SETTLE - 1)) begin
            cnt_q   <= '0;
            state_q <= StDecide;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDecide: begin
          if (bit_q != '0) begin
            ical_q  <= decided;
            bit_q   <= bit_q - 1'b1;
            state_q <= StSettle;
          end else begin
            ical_q  <= clamped;
            last_q  <= clamped;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign dataical = ical_q;
  assign cal_busy = busy_q;
  assign cal_done = done_q;

endmodule

// File: tb/tb_cs_dac_seg_ctrl.sv
// Bench for cs_dac_seg_ctrl: a cycle model built from the behavioural rules is compared every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_cs_dac_seg_ctrl;

  localparam int unsigned LSB  = 6;
  localparam int unsigned T    = 15;
  localparam int unsigned CB   = 5;
  localparam int unsigned CMAX = 22;
  localparam int unsigned CRST = 11;
  localparam int unsigned CS   = 16;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        pdb = 1'b1;
  logic [9:0]  code = '0;
  logic        code_valid = 1'b0;
  logic        mode = 1'b0;
  logic        cal_start = 1'b0;
  logic        cal_cmp;
  logic        cmp_en = 1'b0;
  logic        cmp_fix = 1'b0;
  logic [5:0]  datain, datainb;
  logic [14:0] datatherm, datathermb;
  logic [4:0]  dataical;
  logic        cal_busy, cal_done;

  // Comparator stand-in: Ical above target whenever the trim exceeds 13.
  assign cal_cmp = cmp_en ? (dataical > 5'd13) : cmp_fix;

  cs_dac_seg_ctrl dut (
    .clk        (clk),
    .rstb       (rstb),
    .pdb        (pdb),
    .code       (code),
    .code_valid (code_valid),
    .mode       (mode),
    .cal_start  (cal_start),
    .cal_cmp    (cal_cmp),
    .datain     (datain),
    .datainb    (datainb),
    .datatherm  (datatherm),
    .datathermb (datathermb),
    .dataical   (dataical),
    .cal_busy   (cal_busy),
    .cal_done   (cal_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- behavioural model
  bit          armed = 1'b0;
  bit          m_pv;
  int unsigned m_pc, m_pm, m_ptr, m_din, m_therm;
  bit          m_busy, m_done;
  int unsigned m_t, m_trial, m_ical, m_last;

  initial forever begin
    @(posedge clk);
    if (!rstb) begin
      armed = 1'b1;
      m_pv = 0; m_pc = 0; m_pm = 0; m_ptr = 0; m_din = 0; m_therm = 0;
      m_busy = 0; m_done = 0; m_t = 0; m_trial = 0; m_ical = CRST; m_last = CRST;
    end else if (!pdb) begin
      m_pv = 0; m_din = 0; m_therm = 0; m_ptr = 0;
      m_busy = 0; m_done = 0; m_ical = m_last;
    end else begin
      if (m_pv) begin
        int unsigned kk;
        kk      = m_pc >> LSB;
        m_din   = m_pc & 32'h3F;
        m_therm = 0;
        for (int unsigned i = 0; i < kk; i++) begin
          m_therm |= 32'd1 << (m_pm != 0 ? (m_ptr + i) % T : i);
        end
        if (m_pm != 0) m_ptr = (m_ptr + kk) % T;
      end
      m_pv = code_valid;
      if (code_valid) begin
        m_pc = code;
        m_pm = mode;
      end
      if (m_done) begin
        m_done = 0;
      end else if (m_busy) begin
        m_t++;
        if (m_t % (CS + 1) == 0) begin
          int j;
          j = CB - m_t / (CS + 1);
          if (cal_cmp) m_trial &= ~(32'd1 << j);
          if (j > 0) begin
            m_trial |= 32'd1 << (j - 1);
          end else begin
            m_ical = (m_trial > CMAX) ? CMAX : m_trial;
            m_last = m_ical;
            m_busy = 0;
            m_done = 1;
          end
        end
      end else if (cal_start) begin
        m_busy  = 1;
        m_t     = 0;
        m_trial = 32'd1 << (CB - 1);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (armed) begin
      check("m_datain",     datain,     m_din);
      check("m_datainb",    datainb,    ~m_din & 32'h3F);
      check("m_datatherm",  datatherm,  m_therm);
      check("m_datathermb", datathermb, ~m_therm & 32'h7FFF);
      check("m_dataical",   dataical,   m_busy ? m_trial : m_ical);
      check("m_cal_busy",   cal_busy,   m_busy);
      check("m_cal_done",   cal_done,   m_done);
    end
  end

  // ---------------------------------------------------------------- directed stimulus
  int unsigned trials[$];
  int          exp_trials[5] = '{16, 8, 12, 14, 13};

  task automatic run_cal(input bit pulse, output int n);
    logic [4:0] prev;
    prev = dataical;
    trials.delete();
    cal_start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      cal_start = pulse && (n == 19);
      if (dataical != prev) trials.push_back(dataical);
      prev = dataical;
    end while (!cal_done && n < 200);
    cal_start = 1'b0;
  endtask

  initial begin
    int n;
    bit seen_done;

    // 1: reset with code_valid toggling
    for (int i = 0; i < 4; i++) begin
      code_valid = (i % 2 == 1);
      code = 10'h3FF;
      @(negedge clk);
    end
    check("rst_datain", datain, 6'h00);
    check("rst_datainb", datainb, 6'h3F);
    check("rst_datatherm", datatherm, 15'h0000);
    check("rst_datathermb", datathermb, 15'h7FFF);
    check("rst_dataical", dataical, 11);
    check("rst_cal_busy", cal_busy, 0);
    rstb = 1'b1;
    code_valid = 1'b0;
    repeat (2) @(negedge clk);

    // 2: static decode
    mode = 1'b0; code_valid = 1'b1; code = 10'h3FF;
    @(negedge clk);
    code = 10'h0A5;
    @(negedge clk);
    code_valid = 1'b0;
    check("st_3ff_datain", datain, 6'h3F);
    check("st_3ff_therm", datatherm, 15'h7FFF);
    @(negedge clk);
    check("st_0a5_datain", datain, 6'h25);
    check("st_0a5_therm", datatherm, 15'h0003);
    check("st_0a5_thermb", datathermb, 15'h7FFC);

    // 3: DWA rotation
    mode = 1'b1; code_valid = 1'b1; code = {4'd3, 6'h00};
    @(negedge clk);
    code = {4'd3, 6'h11};
    @(negedge clk);
    check("dwa_1", datatherm, 15'h0007);
    code = {4'd10, 6'h2A};
    @(negedge clk);
    check("dwa_2", datatherm, 15'h0038);
    code_valid = 1'b0;
    @(negedge clk);
    check("dwa_3", datatherm, 15'h7FC1);
    check("dwa_3_datain", datain, 6'h2A);
    repeat (3) @(negedge clk);
    check("dwa_gap_hold", datatherm, 15'h7FC1);
    code_valid = 1'b1; code = {4'd1, 6'h05};
    @(negedge clk);
    code_valid = 1'b0;
    @(negedge clk);
    check("dwa_ptr_is_1", datatherm, 15'h0002);
    mode = 1'b0;

    // 4: calibration, then clamped rerun with a stray cal_start mid-run
    cmp_en = 1'b1;
    run_cal(1'b0, n);
    check("cal1_latency", n, 86);
    check("cal1_done", cal_done, 1);
    check("cal1_result", dataical, 13);
    check("cal1_busy", cal_busy, 0);
    check("cal1_ntrials", trials.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check("cal1_trial", (i < trials.size()) ? trials[i] : 32'hFFFF, exp_trials[i]);
    end
    @(negedge clk);
    check("cal1_done_pulse", cal_done, 0);
    cmp_en = 1'b0; cmp_fix = 1'b0;
    run_cal(1'b1, n);
    check("cal2_latency", n, 86);
    check("cal2_clamped", dataical, 22);
    @(negedge clk);

    // 5: power-down abort at cycle 40
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    repeat (39) @(negedge clk);
    check("abort_pre_busy", cal_busy, 1);
    pdb = 1'b0;
    @(negedge clk);
    check("abort_busy", cal_busy, 0);
    check("abort_ical", dataical, 22);
    check("abort_datain", datain, 0);
    check("abort_therm", datatherm, 0);
    seen_done = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (cal_done) seen_done = 1'b1;
    end
    check("abort_no_done", seen_done, 0);
    pdb = 1'b1;
    @(negedge clk);
    mode = 1'b1; code_valid = 1'b1; code = {4'd3, 6'h07};
    @(negedge clk);
    code_valid = 1'b0;
    @(negedge clk);
    check("pd_ptr_reset", datatherm, 15'h0007);
    check("pd_datain", datain, 6'h07);
    mode = 1'b0;

    // 6: codes ignored while powered down
    pdb = 1'b0; code_valid = 1'b1; code = 10'h3FF;
    repeat (3) @(negedge clk);
    check("pd_therm_zero", datatherm, 0);
    check("pd_datain_zero", datain, 0);
    check("pd_thermb_ones", datathermb, 15'h7FFF);
    pdb = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    check("pu_stage1_only", datatherm, 0);
    @(negedge clk);
    check("pu_therm", datatherm, 15'h7FFF);
    check("pu_datain", datain, 6'h3F);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cs_dac_seg_ctrl.md
Name: cs_dac_seg_ctrl

Overview:
- Digital front-end for the segmented current-steering DAC cell.
- Registers an input code and splits it into an LSB binary field and an MSB field. The MSB field is decoded to a thermometer word, either statically or with data-weighted-averaging (DWA) rotation.
- Drives complementary switch controls (datain/datainb, datatherm/datathermb) plus a SAR calibration sequencer producing dataical from an analog comparator.
- Sits between the digital datapath and the analog currentSterring array.

Parameters:
LSB_BITS, 6, width of binary-weighted field (datain)
MSB_BITS, 4, width of MSB field; thermometer length THERM = 2**MSB_BITS - 1
CAL_BITS, 5, width of dataical
CAL_MAX, 22, largest legal dataical; SAR result is clamped to this
CAL_RESET, 11, dataical value after reset and after aborted calibration
CAL_SETTLE, 16, settle cycles before each comparator decision (>=1)

Ports:
clk  in  1  clock
rstb  in  1  synchronous active-low reset
pdb  in  1  power-down bar; 0 = powered down
code  in  LSB_BITS+MSB_BITS  DAC input code; MSB field = upper MSB_BITS bits
code_valid  in  1  code accepted on rising clk when 1
mode  in  1  0 = static thermometer, 1 = DWA rotation
cal_start  in  1  one-cycle request to run calibration
cal_cmp  in  1  comparator: 1 = Ical above target (trial too high)
datain  out  LSB_BITS  binary switch controls
datainb  out  LSB_BITS  complement of datain
datatherm  out  THERM  thermometer switch controls
datathermb  out  THERM  complement of datatherm
dataical  out  CAL_BITS  calibration trim code
cal_busy  out  1  calibration in progress
cal_done  out  1  one-cycle pulse on successful completion

Behaviour:
- Reset (rstb=0 at clk edge):
  - datain=0, datatherm=0, datainb=all 1, datathermb=all 1.
  - dataical=CAL_RESET, cal_busy=0, cal_done=0.
  - DWA pointer ptr=0, pipeline stages cleared, FSM to IDLE.
- Pipeline, 2 cycles:
  - Stage 1 captures code when code_valid=1 and pdb=1.
  - Stage 2 registers the decoded outputs.
  - A code presented at edge N appears on outputs after edge N+2.
  - No code_valid: outputs hold.
- Complement rule: datainb==~datain and datathermb==~datatherm on every cycle, including reset and power-down. Both words come from the same register.
- Static decode (mode=0): k = MSB field; datatherm bits [k-1:0]=1, rest 0. k=0 gives all zero.
- DWA decode (mode=1):
  - Set k consecutive bits starting at ptr, wrapping modulo THERM.
  - Then ptr <= (ptr+k) mod THERM.
  - ptr updates only on accepted codes. mode is sampled with the code in stage 1.
  - ptr holds while mode=0.
- pdb=0:
  - Stage 1/2 forced to zero code next edge, so datain=0 and datatherm=0 after one edge.
  - code_valid ignored; ptr reset to 0.
- Calibration FSM states: IDLE, SETTLE, DECIDE, DONE.
  - IDLE: on cal_start=1 and pdb=1, go to SETTLE with trial bit b=CAL_BITS-1. dataical = 1<<b, cal_busy=1.
  - SETTLE: count CAL_SETTLE cycles, then go to DECIDE.
  - DECIDE (1 cycle): if cal_cmp=1, clear bit b. If b>0, set bit b-1 and go to SETTLE; else go to DONE.
  - DONE (1 cycle): dataical=min(result, CAL_MAX); cal_done=1, cal_busy=0; go to IDLE.
  - Latency: cal_start at edge N gives cal_done high in cycle N + CAL_BITS*(CAL_SETTLE+1) + 1 (86 with defaults).
  - cal_start while cal_busy=1 is ignored.
  - pdb=0 during calibration: abort at next edge to IDLE, cal_busy=0, no cal_done. dataical restored to the last completed value (CAL_RESET if none).
  - rstb=0 mid-calibration: full reset values.
  - The DAC datapath keeps operating during calibration.

Test Plan:
1. Reset with code_valid toggling -> datain=6'h00, datainb=6'h3F, datatherm=15'h0000, datathermb=15'h7FFF, dataical=11, cal_busy=0.
2. mode=0, code=10'h3FF then 10'h0A5 on consecutive cycles -> two and three edges later: datain=6'h3F, datatherm=15'h7FFF; then datain=6'h25, datatherm=15'h0003. Complements hold every cycle.
3. mode=1, MSB fields 3, 3, 10 (ptr 0 to 3 to 6) -> datatherm 15'h0007, 15'h0038, 15'h7FC1; ptr ends at 1. A gap without code_valid leaves outputs and ptr unchanged.
4. Calibration with cal_cmp modelled as (dataical>13) -> trials 16, 8, 12, 14, 13. cal_done pulses 86 cycles after cal_start with dataical=13. Rerun with cal_cmp=0 -> result 31 clamped to dataical=22.
5. cal_start, then pdb=0 at cycle 40 -> cal_busy=0 next edge, no cal_done, dataical=22 (last completed), data outputs zero, ptr=0. A cal_start pulse at cycle 20 of a run has no effect.
6. pdb=0 with code_valid=1 and code=10'h3FF -> outputs stay zero. pdb=1 -> next accepted code appears two edges later.
